aes_shiftrows_pipe: RTL and testbench
=====================================

AES_SHIFTROWS_PIPE -- requirements
Module: aes_shiftrows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns (Rijndael Nb); legal values are 4, 6 and 8.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port in_valid: input, 1 bit, the input beat is valid.
REQ-006 Port in_ready: output, 1 bit, the block accepts the input beat.
REQ-007 Port in_inv: input, 1 bit, mode for the beat: 0 = ShiftRows, 1 = InvShiftRows.
REQ-008 Port in_state: input, [0:32*NB-1], state, big-endian, column-major.
REQ-009 Port out_valid: output, 1 bit, the output beat is valid.
REQ-010 Port out_ready: input, 1 bit, downstream accepts the output beat.
REQ-011 Port out_inv: output, 1 bit, in_inv echoed with its beat.
REQ-012 Port out_state: output, [0:32*NB-1], transformed state.
REQ-013 Port beat_cnt: output, 16 bits, count of completed output transfers.

Function
REQ-014 Byte (row r, column c) SHALL occupy bits [8*(4c+r) : 8*(4c+r)+7], with r in 0..3 and c in 0..NB-1.
REQ-015 Row shift offsets SHALL be {0,1,2,3} for NB=4 and NB=6, and {0,1,3,4} for NB=8.
REQ-016 Forward mode SHALL compute out[r][c] = in[r][(c+s_r) mod NB].
REQ-017 Inverse mode SHALL compute out[r][c] = in[r][(c-s_r) mod NB], with the modulo wrapping non-negative.
REQ-018 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-019 Latency SHALL be 1 cycle: a beat accepted at edge k SHALL appear on out_state/out_inv with out_valid=1 after edge k.
REQ-020 While out_valid=1 and out_ready=0, out_state, out_inv and out_valid SHALL hold stable.
REQ-021 Order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-022 On a simultaneous input and output transfer in the same cycle, the new beat SHALL replace the departing one with no bubble, so full throughput is 1 beat per cycle.
REQ-023 Each beat's mode SHALL be taken from in_inv at its own transfer; mixed-mode back-to-back beats SHALL be legal.
REQ-024 in_state/in_inv SHALL be ignored when no input transfer occurs.
REQ-025 beat_cnt SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-026 An NB value outside {4,6,8} SHALL produce an elaboration-time error.

Reset
REQ-027 When rst=1 at a clock edge, out_valid SHALL be 0, beat_cnt 0, out_state all-zero and out_inv 0; any skid content SHALL be discarded.
REQ-028 rst SHALL take priority over simultaneous transfers; a beat in flight at reset SHALL be lost, and no transfer SHALL be counted in that cycle.
REQ-029 In the cycle after reset deasserts, in_ready SHALL be 1.

Configuration
REQ-030 With macro AES_SHIFTROWS_SKID_EN defined, the block SHALL add a one-entry skid register and make in_ready a register output equal to "skid empty"; a beat arriving while the output stalls SHALL park in the skid and move to the output on the next out_ready=1; latency SHALL stay 1 cycle when unstalled.
REQ-031 Without AES_SHIFTROWS_SKID_EN, in_ready SHALL be combinational: ~out_valid | out_ready, with no skid storage.

Verification
REQ-032 Forward, NB=4: in_state=00 01 02 ... 0f, in_inv=0, out_ready=1 -> next cycle out_state=00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, out_valid=1, beat_cnt=1.
REQ-033 Inverse, NB=4: same input with in_inv=1 -> out_state=00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03, out_inv=1.
REQ-034 Round trip for NB=4, 6 and 8: 1000 random states are passed forward, then fed back inverse -> each original is recovered; for NB=8, row 3 byte of column 0 equals in[3][4].
REQ-035 Backpressure: 10 back-to-back beats with random out_ready (~50%) -> 10 outputs in order, data stable while stalled, beat_cnt=10; with AES_SHIFTROWS_SKID_EN, in_ready never depends combinationally on out_ready.
REQ-036 Reset mid-stream: rst=1 while out_valid=1 and out_ready=0 -> next cycle out_valid=0 and beat_cnt=0, and in_ready=1 after deassertion.
REQ-037 Counter wrap: a preload or 65536 transfers -> beat_cnt returns to 0.

Source files
------------

// File: rtl/aes_shiftrows_pipe.sv
// AES ShiftRows / InvShiftRows stage with a valid/ready handshake and a 1-cycle output register.
// Optional one-entry skid buffer (registered in_ready) enabled with macro AES_SHIFTROWS_SKID_EN.
module aes_shiftrows_pipe #(
   parameter int NB = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_inv,
   input  logic [0:32*NB-1]  in_state,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_inv,
   output logic [0:32*NB-1]  out_state,
   output logic [15:0]       beat_cnt
);

   localparam int W = 32 * NB;

   generate
      if (NB != 4 && NB != 6 && NB != 8) begin : g_nb_check
         $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
      end
   endgenerate

   // Rijndael row offsets: rows 2 and 3 shift one extra column when NB=8.
   function automatic int row_off(input int r);
      if (NB == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   logic [0:W-1] shifted;

   for (genvar gr = 0; gr < 4; gr++) begin : g_row
      for (genvar gc = 0; gc < NB; gc++) begin : g_col
         localparam int FWD = (gc + row_off(gr)) % NB;
         localparam int INV = (gc - row_off(gr) + NB) % NB;
         assign shifted[8*(4*gc+gr) +: 8] = in_inv ? in_state[8*(4*INV+gr) +: 8]
                                                   : in_state[8*(4*FWD+gr) +: 8];
      end
   end

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else if (out_fire) begin
         beat_cnt <= beat_cnt + 16'd1;
      end
   end

`ifdef AES_SHIFTROWS_SKID_EN
   logic          skid_empty;
   logic          skid_inv;
   logic [0:W-1]  skid_state;

   assign in_ready = skid_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_inv    <= 1'b0;
         out_state  <= '0;
         skid_empty <= 1'b1;
         skid_inv   <= 1'b0;
         skid_state <= '0;
      end else if (!out_valid || out_ready) begin
         // Output slot is free this edge; a parked beat has priority over new input.
         if (!skid_empty) begin
            out_valid  <= 1'b1;
            out_inv    <= skid_inv;
            out_state  <= skid_state;
            skid_empty <= 1'b1;
         end else if (in_fire) begin
            out_valid <= 1'b1;
            out_inv   <= in_inv;
            out_state <= shifted;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_fire) begin
         skid_inv   <= in_inv;
         skid_state <= shifted;
         skid_empty <= 1'b0;
      end
   end
`else
   assign in_ready = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_inv   <= 1'b0;
         out_state <= '0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
         out_inv   <= in_inv;
         out_state <= shifted;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Directed/table-driven bench for aes_shiftrows_pipe: NB=4 handshake tests plus
// NB=4/6/8 round-trip instances with out_ready tied high.
module tb_aes_shiftrows_pipe;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_inv;
   logic [0:127]  in_state;
   logic          out_valid;
   logic          out_ready;
   logic          out_inv;
   logic [0:127]  out_state;
   logic [15:0]   beat_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aes_shiftrows_pipe #(.NB(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
      .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
      .out_state(out_state), .beat_cnt(beat_cnt)
   );

   // round-trip instances
   logic          rt_valid, rt_inv;
   logic [0:127]  rt_in4, o4;
   logic [0:191]  rt_in6, o6;
   logic [0:255]  rt_in8, o8;
   logic          r4, r6, r8, v4, v6, v8, i4, i6, i8;
   logic [15:0]   c4, c6, c8;

   aes_shiftrows_pipe #(.NB(4)) rt4 (
      .clk(clk), .rst(rst), .in_valid(rt_valid), .in_ready(r4), .in_inv(rt_inv),
      .in_state(rt_in4), .out_valid(v4), .out_ready(1'b1), .out_inv(i4),
      .out_state(o4), .beat_cnt(c4)
   );
   aes_shiftrows_pipe #(.NB(6)) rt6 (
      .clk(clk), .rst(rst), .in_valid(rt_valid), .in_ready(r6), .in_inv(rt_inv),
      .in_state(rt_in6), .out_valid(v6), .out_ready(1'b1), .out_inv(i6),
      .out_state(o6), .beat_cnt(c6)
   );
   aes_shiftrows_pipe #(.NB(8)) rt8 (
      .clk(clk), .rst(rst), .in_valid(rt_valid), .in_ready(r8), .in_inv(rt_inv),
      .in_state(rt_in8), .out_valid(v8), .out_ready(1'b1), .out_inv(i8),
      .out_state(o8), .beat_cnt(c8)
   );

   typedef struct {
      logic [0:127] st;
      logic         inv;
      logic [0:127] exp;
   } vec_t;

   typedef struct {
      logic [0:127] st;
      logic         inv;
   } beat_t;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Reference: out[r][c] = in[r][(c +/- s_r) mod nb]
   function automatic logic [0:255] ref_shift(input logic [0:255] s, input int nb, input logic inv);
      logic [0:255] o;
      int sh, src;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         sh = (nb == 8 && r >= 2) ? r + 1 : r;
         for (int c = 0; c < nb; c++) begin
            src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
            o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [0:255] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t          vt[5];
   beat_t         q[$];
   beat_t         b;
   logic [0:255]  x, e, y;
   logic [0:127]  prev_state;
   logic          prev_inv, hold;
   int            sent, got, n;
   logic [15:0]   base;
   bit            done;

   initial begin
      vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h00050a0f04090e03080d02070c01060b};
      vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 128'h000d0a0704010e0b0805020f0c090603};
      vt[2] = '{128'h101112131415161718191a1b1c1d1e1f, 1'b0, 128'h10151a1f14191e13181d12171c11161b};
      vt[3] = '{128'h00050a0f04090e03080d02070c01060b, 1'b1, 128'h000102030405060708090a0b0c0d0e0f};
      vt[4] = '{128'h101112131415161718191a1b1c1d1e1f, 1'b1, 128'h101d1a1714111e1b1815121f1c191613};

      rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b0;
      rt_valid = 1'b0; rt_inv = 1'b0; rt_in4 = '0; rt_in6 = '0; rt_in8 = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_beat_cnt", beat_cnt, 0);
      chk("reset_out_state", out_state, 0);
      chk("reset_out_inv", out_inv, 0);
      chk("reset_in_ready", in_ready, 1);

      // table vectors, one isolated beat each
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_state = vt[i].st; in_inv = vt[i].inv; out_ready = 1'b1;
         tick();
         in_valid = 1'b0; in_state = ~vt[i].st; in_inv = ~vt[i].inv;
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_state", i), out_state, vt[i].exp);
         chk($sformatf("vec%0d_inv", i), out_inv, vt[i].inv);
         tick();
         chk($sformatf("vec%0d_drain", i), out_valid, 0);
         chk($sformatf("vec%0d_cnt", i), beat_cnt, i + 1);
      end

      // backpressure: 10 back-to-back beats, random out_ready, mixed modes
      base = beat_cnt; sent = 0; got = 0; hold = 1'b0;
      for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
         if (hold) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_state", out_state, prev_state);
            chk("stall_inv", out_inv, prev_inv);
         end
         in_valid = (sent < 10);
         x = rand256();
         in_state = x[0:127];
         in_inv = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready) begin
            e = ref_shift({in_state, 128'b0}, 4, in_inv);
            b.st = e[0:127]; b.inv = in_inv;
            q.push_back(b);
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("bp_unexpected_out", 1, 0);
            end else begin
               b = q.pop_front();
               chk($sformatf("bp_state%0d", got), out_state, b.st);
               chk($sformatf("bp_inv%0d", got), out_inv, b.inv);
            end
            got++;
         end
         hold = out_valid && !out_ready;
         prev_state = out_state; prev_inv = out_inv;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("bp_outputs", got, 10);
      chk("bp_beat_cnt", beat_cnt, base + 16'd10);

      // reset mid-stream while stalled, with transfers requested on the reset edge
      in_valid = 1'b1; in_state = vt[0].st; in_inv = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      chk("mid_stalled_valid", out_valid, 1);
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt", beat_cnt, 0);
      chk("mid_rst_state", out_state, 0);
      chk("mid_rst_inv", out_inv, 0);
      rst = 1'b0; in_valid = 1'b0;
      tick();
      chk("mid_in_ready", in_ready, 1);
      chk("mid_valid_after", out_valid, 0);

      // round trip NB=4/6/8
      for (int k = 0; k < 1000; k++) begin
         x = rand256();
         rt_in4 = x[0:127]; rt_in6 = x[0:191]; rt_in8 = x;
         rt_inv = 1'b0; rt_valid = 1'b1;
         tick();
         e = ref_shift(x, 4, 1'b0);
         chk("rt4_fwd", {o4, 128'b0}, e);
         e = ref_shift(x, 6, 1'b0);
         chk("rt6_fwd", {o6, 64'b0}, e);
         e = ref_shift(x, 8, 1'b0);
         chk("rt8_fwd", o8, e);
         chk("rt8_r3c0", o8[24 +: 8], x[152 +: 8]);
         chk("rt_valid", {v4, v6, v8, r4, r6, r8}, 6'b111111);
         rt_in4 = o4; rt_in6 = o6; rt_in8 = o8; rt_inv = 1'b1;
         tick();
         y = x;
         chk("rt4_back", o4, y[0:127]);
         chk("rt6_back", o6, y[0:191]);
         chk("rt8_back", o8, y);
         chk("rt_inv", {i4, i6, i8}, 3'b111);
      end
      rt_valid = 1'b0;

      // counter wrap after 65536 output transfers
      rst = 1'b1; tick(); rst = 1'b0;
      in_valid = 1'b1; in_state = vt[2].st; in_inv = 1'b0; out_ready = 1'b1;
      n = 0; done = 1'b0;
      for (int cyc = 0; cyc < 66000 && !done; cyc++) begin
         #1;
         if (out_valid && out_ready) n++;
         @(posedge clk);
         #1;
         if (n == 65535) chk("wrap_ffff", beat_cnt, 16'hFFFF);
         if (n == 65536) begin
            chk("wrap_zero", beat_cnt, 0);
            done = 1'b1;
         end
      end
      chk("wrap_reached", done, 1);
      in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
